usbfs_endp_tx: RTL and testbench



---
 rtl/usbfs_endp_tx.sv | 190 +++++++++++++++++++
 tb/tb_usbfs_endp_tx.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbfs_endp_tx.sv
// ---------------------------------------------------------------------------
// usbfs_endp_tx
//
// Device-to-host (IN) endpoint data path for the USB full-speed device stack.
// User bytes arrive over a valid/ready stream and are queued in a small FIFO.
// While filling, the head byte is copied into the transactor's packet buffer
// one byte per cycle.  A packet is offered to the transactor when it is full
// (MAX_PKT bytes), when the stream has been idle for TIMEOUT cycles, or when
// the user requests a flush.  The transactor owns the buffer (and retries
// the packet) until it reports the host ACK via i_etReady.
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_valid      upstream byte valid
//   o_ready      upstream ready (FIFO not full)
//   i_data       upstream byte
//   i_flush      single-cycle request to offer the partial packet now
//   o_etValid    packet in transactor buffer is ready to send
//   i_etReady    transactor sent the packet and saw the host ACK
//   o_etStall    endpoint halt (never used, tied low)
//   o_etWrEn     write strobe into the transactor buffer
//   o_etWrIdx    byte index of the write
//   o_etWrByte   byte being written
//   o_etNBytes   packet length, meaningful while o_etValid
// ---------------------------------------------------------------------------
module usbfs_endp_tx #(
    parameter int MAX_PKT    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [7:0]                     i_data,
    input  logic                           i_flush,
    output logic                           o_etValid,
    input  logic                           i_etReady,
    output logic                           o_etStall,
    output logic                           o_etWrEn,
    output logic [$clog2(MAX_PKT)-1:0]     o_etWrIdx,
    output logic [7:0]                     o_etWrByte,
    output logic [$clog2(MAX_PKT+1)-1:0]   o_etNBytes
);

    localparam int IDX_W = $clog2(MAX_PKT);
    localparam int NB_W  = $clog2(MAX_PKT + 1);
    localparam int TM_W  = $clog2(TIMEOUT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [NB_W-1:0]  NB_MAX    = NB_W'(MAX_PKT);
    localparam logic [TM_W-1:0]  TM_SAT    = TM_W'(TIMEOUT);
    localparam logic [TM_W-1:0]  TM_LAST   = TM_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Idle timer counts up and sticks at TIMEOUT rather than wrapping.
    function automatic logic [TM_W-1:0] sat_inc(input logic [TM_W-1:0] v);
        return (v == TM_SAT) ? v : v + TM_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Byte FIFO: head is read combinationally, push and pop may coincide.
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    assign full  = (count_q == FIFO_FULL);
    assign empty = (count_q == '0);
    assign push  = i_valid && !full;
    assign head  = mem[rd_ptr_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only, so it is not reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM: FILL copies bytes into the transactor buffer, OFFER
    // hands the buffer over until the host ACK arrives.
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [NB_W-1:0]  nbytes_q, nbytes_d;
    logic [NB_W-1:0]  nb_inc;
    logic [TM_W-1:0]  timer_q, timer_d;
    logic             flush_q, flush_d;

    assign nb_inc = nbytes_q + NB_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_FILL;
            nbytes_q <= '0;
            timer_q  <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            nbytes_q <= nbytes_d;
            timer_q  <= timer_d;
            flush_q  <= flush_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        nbytes_d  = nbytes_q;
        timer_d   = timer_q;
        flush_d   = flush_q;
        pop       = 1'b0;
        o_etWrEn  = 1'b0;
        o_etValid = 1'b0;

        unique case (state_q)
            ST_FILL: begin
                pop = !empty && (nbytes_q < NB_MAX);
                if (pop) begin
                    o_etWrEn = 1'b1;
                    nbytes_d = nb_inc;
                    timer_d  = '0;
                    // A flush arriving alongside a write is remembered and
                    // honoured once the stream pauses.
                    if (i_flush) begin
                        flush_d = 1'b1;
                    end
                    if (nb_inc == NB_MAX) begin
                        state_d = ST_OFFER;
                    end
                end else if (nbytes_q != '0) begin
                    timer_d = sat_inc(timer_q);
                    if ((timer_q == TM_LAST) || i_flush || flush_q) begin
                        state_d = ST_OFFER;
                    end
                end
            end
            ST_OFFER: begin
                o_etValid = 1'b1;
                if (i_etReady) begin
                    state_d  = ST_FILL;
                    nbytes_d = '0;
                    timer_d  = '0;
                    flush_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign o_ready    = !full;
    assign o_etStall  = 1'b0;
    assign o_etWrIdx  = nbytes_q[IDX_W-1:0];
    assign o_etWrByte = head;
    assign o_etNBytes = nbytes_q;

endmodule

// File: tb/tb_usbfs_endp_tx.sv
// ---------------------------------------------------------------------------
// tb_usbfs_endp_tx
//
// Self-checking bench for usbfs_endp_tx (MAX_PKT=8, FIFO_DEPTH=16,
// TIMEOUT=16).  Directed scenarios cover the packet-forming rules; a random
// phase checks the byte stream against a queue-based reference of the
// endpoint (bytes in order, per-packet index, FIFO occupancy, offer/hold).
// Outputs are sampled 1 time unit after each rising edge, where inputs are
// also updated.
// ---------------------------------------------------------------------------
module tb_usbfs_endp_tx;

    localparam int MAX_PKT    = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 16;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       valid    = 1'b0;
    logic [7:0] data     = 8'h00;
    logic       flush    = 1'b0;
    logic       et_ready = 1'b0;
    logic       ready;
    logic       et_valid;
    logic       et_stall;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_byte;
    logic [3:0] nbytes;

    int n_checks = 0;
    int n_fail   = 0;

    bit [7:0] sent[$];
    int       acc;

    usbfs_endp_tx #(
        .MAX_PKT   (MAX_PKT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid),
        .o_ready   (ready),
        .i_data    (data),
        .i_flush   (flush),
        .o_etValid (et_valid),
        .i_etReady (et_ready),
        .o_etStall (et_stall),
        .o_etWrEn  (wr_en),
        .o_etWrIdx (wr_idx),
        .o_etWrByte(wr_byte),
        .o_etNBytes(nbytes)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid    = 1'b0;
        flush    = 1'b0;
        et_ready = 1'b0;
        rst_n    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        sent.delete();
        acc = 0;
    endtask

    // Offer one byte upstream while fewer than 'limit' have been accepted,
    // recording it when the handshake will take place at the next edge.
    task automatic drive_push(input int limit);
        if (acc < limit) begin
            valid = 1'b1;
            data  = 8'($urandom);
            if (ready) begin
                sent.push_back(data);
                acc++;
            end
        end else begin
            valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        valid = 1'b0;
        rst_n = 1'b0;
        step();
        n_checks++;
        if (et_valid !== 1'b0 || wr_en !== 1'b0 || wr_idx !== 3'd0 || nbytes !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b wren=%b idx=%0d nbytes=%0d, required 0 0 0 0",
                     et_valid, wr_en, wr_idx, nbytes);
        end
        n_checks++;
        if (ready !== 1'b1 || et_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_stall: ready=%b stall=%b, required 1 0", ready, et_stall);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (et_valid !== 1'b0 || wr_en !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b wren=%b ready=%b, required 0 0 1",
                     et_valid, wr_en, ready);
        end
    endtask

    task automatic test_full_packet();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            data  = 8'h10 + 8'(i);
            step();
            n_checks++;
            if (wr_en !== 1'b1 || wr_idx !== 3'(i) || wr_byte !== 8'h10 + 8'(i)) begin
                n_fail++;
                $display("FAIL full_write%0d: wren=%b idx=%0d byte=%h, required 1 %0d %h",
                         i, wr_en, wr_idx, wr_byte, i, 8'h10 + 8'(i));
            end
        end
        valid = 1'b0;
        step();
        n_checks++;
        if (et_valid !== 1'b1 || nbytes !== 4'd8 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL full_offer: valid=%b nbytes=%0d wren=%b, required 1 8 0",
                     et_valid, nbytes, wr_en);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (et_valid !== 1'b1 || nbytes !== 4'd8) begin
                n_fail++;
                $display("FAIL full_hold%0d: valid=%b nbytes=%0d, required 1 8", i, et_valid, nbytes);
            end
        end
        et_ready = 1'b1;
        step();
        et_ready = 1'b0;
        n_checks++;
        if (et_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_after_ack: valid=%b, required 0", et_valid);
        end
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            data  = 8'h40 + 8'(i);
            step();
            n_checks++;
            if (wr_en !== 1'b1 || wr_idx !== 3'(i) || wr_byte !== 8'h40 + 8'(i)) begin
                n_fail++;
                $display("FAIL timeout_write%0d: wren=%b idx=%0d byte=%h, required 1 %0d %h",
                         i, wr_en, wr_idx, wr_byte, i, 8'h40 + 8'(i));
            end
        end
        valid = 1'b0;
        // TIMEOUT idle cycles follow the last write; the offer shows on the next one.
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (et_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || n != TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: offer seen=%0d after %0d cycles, required after %0d",
                     seen, n, TIMEOUT + 1);
        end
        n_checks++;
        if (nbytes !== 4'd3) begin
            n_fail++;
            $display("FAIL timeout_nbytes: nbytes=%0d, required 3", nbytes);
        end
        et_ready = 1'b1;
        step();
        et_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int  nw;
        bit  wr_in_offer;
        do_reset();
        nw          = 0;
        wr_in_offer = 1'b0;
        drive_push(30);
        for (int c = 0; c < 60; c++) begin
            step();
            if (wr_en === 1'b1) begin
                if (et_valid === 1'b1) wr_in_offer = 1'b1;
                n_checks++;
                if (wr_idx !== 3'(nw) || wr_byte !== sent[nw]) begin
                    n_fail++;
                    $display("FAIL bp_write%0d: idx=%0d byte=%h, required %0d %h",
                             nw, wr_idx, wr_byte, nw, sent[nw]);
                end
                nw++;
            end
            drive_push(30);
        end
        n_checks++;
        if (wr_in_offer || nw != 8) begin
            n_fail++;
            $display("FAIL bp_writes: writes=%0d write_during_offer=%0d, required 8 0", nw, wr_in_offer);
        end
        n_checks++;
        if (et_valid !== 1'b1 || nbytes !== 4'd8 || ready !== 1'b0 || acc != 8 + FIFO_DEPTH) begin
            n_fail++;
            $display("FAIL bp_full: valid=%b nbytes=%0d ready=%b accepted=%0d, required 1 8 0 %0d",
                     et_valid, nbytes, ready, acc, 8 + FIFO_DEPTH);
        end
        et_ready = 1'b1;
        drive_push(30);
        step();
        et_ready = 1'b0;
        n_checks++;
        if (et_valid !== 1'b0 || wr_en !== 1'b1 || wr_idx !== 3'd0 || wr_byte !== sent[8]) begin
            n_fail++;
            $display("FAIL bp_resume: valid=%b wren=%b idx=%0d byte=%h, required 0 1 0 %h",
                     et_valid, wr_en, wr_idx, wr_byte, sent[8]);
        end
        valid = 1'b0;
    endtask

    task automatic test_flush();
        bit spurious;
        do_reset();
        flush = 1'b1;
        step();
        flush    = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (et_valid !== 1'b0 || wr_en !== 1'b0) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) begin
            n_fail++;
            $display("FAIL flush_empty: offer or write seen=1, required 0");
        end

        // Flush on an idle cycle after five writes.
        for (int i = 0; i < 5; i++) begin
            drive_push(5);
            step();
        end
        valid = 1'b0;
        n_checks++;
        if (wr_en !== 1'b1 || wr_idx !== 3'd4 || wr_byte !== sent[4]) begin
            n_fail++;
            $display("FAIL flush_fifth_write: wren=%b idx=%0d byte=%h, required 1 4 %h",
                     wr_en, wr_idx, wr_byte, sent[4]);
        end
        step();
        n_checks++;
        if (et_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_early: valid=%b, required 0", et_valid);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (et_valid !== 1'b1 || nbytes !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_offer: valid=%b nbytes=%0d, required 1 5", et_valid, nbytes);
        end
        et_ready = 1'b1;
        step();
        et_ready = 1'b0;

        // Flush coinciding with the fifth write.
        sent.delete();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            drive_push(5);
            step();
        end
        valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (et_valid !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_coinc_gap: valid=%b wren=%b, required 0 0", et_valid, wr_en);
        end
        step();
        n_checks++;
        if (et_valid !== 1'b1 || nbytes !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_coinc_offer: valid=%b nbytes=%0d, required 1 5", et_valid, nbytes);
        end
        et_ready = 1'b1;
        step();
        et_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int guard;
        do_reset();
        guard = 0;
        drive_push(11);
        step();
        while (et_valid !== 1'b1 && guard < 30) begin
            drive_push(11);
            step();
            guard++;
        end
        n_checks++;
        if (et_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_offer: valid=%b after %0d cycles, required 1", et_valid, guard);
        end
        et_ready = 1'b1;
        drive_push(11);
        step();
        et_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (wr_en !== 1'b1 || wr_idx !== 3'(k) || wr_byte !== sent[8 + k]) begin
                n_fail++;
                $display("FAIL b2b_write%0d: wren=%b idx=%0d byte=%h, required 1 %0d %h",
                         k, wr_en, wr_idx, wr_byte, k, sent[8 + k]);
            end
            drive_push(11);
            step();
        end
        valid = 1'b0;
    endtask

    task automatic test_async_reset();
        int  guard;
        bit  spurious;
        do_reset();
        guard = 0;
        drive_push(8);
        step();
        while (et_valid !== 1'b1 && guard < 30) begin
            drive_push(8);
            step();
            guard++;
        end
        valid = 1'b0;
        n_checks++;
        if (et_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_offer: valid=%b, required 1", et_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (et_valid !== 1'b0 || nbytes !== 4'd0 || ready !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: valid=%b nbytes=%0d ready=%b wren=%b, required 0 0 1 0",
                     et_valid, nbytes, ready, wr_en);
        end
        step();
        rst_n    = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wr_en !== 1'b0 || et_valid !== 1'b0 || nbytes !== 4'd0 || ready !== 1'b1)
                spurious = 1'b1;
        end
        n_checks++;
        if (spurious) begin
            n_fail++;
            $display("FAIL areset_after: activity without push seen=1, required 0");
        end
    endtask

    task automatic test_random();
        int  occ;
        int  pkt;
        int  dens;
        bit  must_valid;
        bit  exp_wr;
        bit  pushed;
        bit  popped;
        bit  acked;
        do_reset();
        occ        = 0;
        pkt        = 0;
        dens       = 50;
        must_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 100 == 0) dens = $urandom_range(0, 100);

            n_checks++;
            if (ready !== (occ < FIFO_DEPTH)) begin
                n_fail++;
                $display("FAIL rnd_ready c%0d: ready=%b, required %0d (occupancy %0d)",
                         cyc, ready, occ < FIFO_DEPTH, occ);
            end
            exp_wr = (et_valid !== 1'b1) && (occ > 0);
            n_checks++;
            if (wr_en !== exp_wr) begin
                n_fail++;
                $display("FAIL rnd_wren c%0d: wren=%b, required %0d", cyc, wr_en, exp_wr);
            end
            popped = 1'b0;
            if (wr_en === 1'b1 && sent.size() > 0) begin
                n_checks++;
                if (wr_idx !== 3'(pkt) || wr_byte !== sent[0]) begin
                    n_fail++;
                    $display("FAIL rnd_write c%0d: idx=%0d byte=%h, required %0d %h",
                             cyc, wr_idx, wr_byte, pkt, sent[0]);
                end
                void'(sent.pop_front());
                pkt++;
                popped = 1'b1;
            end
            if (must_valid) begin
                n_checks++;
                if (et_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_hold c%0d: valid=%b, required 1", cyc, et_valid);
                end
            end
            if (et_valid === 1'b1) begin
                n_checks++;
                if (nbytes !== 4'(pkt) || pkt < 1 || pkt > MAX_PKT) begin
                    n_fail++;
                    $display("FAIL rnd_nbytes c%0d: nbytes=%0d, required %0d in 1..%0d",
                             cyc, nbytes, pkt, MAX_PKT);
                end
            end

            et_ready = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 31) == 0);
            valid    = ($urandom_range(0, 99) < dens);
            data     = 8'($urandom);
            pushed   = valid && (ready === 1'b1);
            if (pushed) sent.push_back(data);

            occ        = occ + int'(pushed) - int'(popped);
            acked      = (et_valid === 1'b1) && et_ready;
            must_valid = ((et_valid === 1'b1) && !et_ready) || (popped && pkt == MAX_PKT);
            if (acked) pkt = 0;
            step();
        end
        valid    = 1'b0;
        flush    = 1'b0;
        et_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_timeout();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
